// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and defaults for the UART receive-line conditioner.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int C_BREAK_BITS_DFLT = 10;
  localparam int C_IDLE_BITS_DFLT  = 10;

  // Same width as the bus wrapper's rate register
  typedef logic [15:0] rate_t;

  typedef enum logic [1:0] {
    ST_IDLE_HI = 2'd0,
    ST_LOW     = 2'd1,
    ST_BREAK   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_conditioner_if
// Brief   : Line input, rate/clear controls and conditioned outputs.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_rx_conditioner_if;

  logic           i_rx_pad;
  uart_pkg::rate_t i_rate;
  logic           i_clear;
  logic           o_rx_out;
  logic           o_break_start;
  logic           o_break_active;
  logic           o_break_end;
  logic           o_idle_pulse;

  modport master (
    output i_rx_pad, i_rate, i_clear,
    input  o_rx_out, o_break_start, o_break_active, o_break_end, o_idle_pulse
  );

  modport slave (
    input  i_rx_pad, i_rate, i_clear,
    output o_rx_out, o_break_start, o_break_active, o_break_end, o_idle_pulse
  );

endinterface
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module  : uart_sync
// Brief   : Multi-flop synchronizer for an idle-high asynchronous line.
// Revision: 1.0 - initial release
// ============================================================================
module uart_sync #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic nReset,
  input  wire logic i_d,
  output logic      o_q
);

  logic [STAGES-1:0] r_sync;

  // Reset to the idle level so a reset never looks like a start bit
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_conditioner
// Brief   : Synchronizes and majority-filters a UART rx line; detects break/idle.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_conditioner
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int BREAK_BITS  = C_BREAK_BITS_DFLT,
  parameter int IDLE_BITS   = C_IDLE_BITS_DFLT
) (
  input wire logic              clk,
  input wire logic              nReset,
  uart_rx_conditioner_if.slave  bus
);

  logic                  w_sync;
  logic [FILTER_LEN-1:0] r_filt;
  int                    w_ones;
  logic                  w_maj;
  logic                  r_rx_out;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_edge;

  rate_t                 r_cnt;
  rate_t                 w_eff_rate_m1;
  logic                  w_wrap;
  logic [4:0]            r_bits;
  logic [4:0]            w_bits_nxt;
  logic                  w_bits_inc;
  logic                  w_hit_break;
  logic                  w_hit_idle;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_idle_armed;
  logic                  w_break_start_nxt;
  logic                  w_break_end_nxt;
  logic                  w_idle_nxt;
  logic                  r_break_start;
  logic                  r_break_active;
  logic                  r_break_end;
  logic                  r_idle_pulse;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .nReset (nReset),
    .i_d    (bus.i_rx_pad),
    .o_q    (w_sync)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_filt   <= '1;
      r_rx_out <= 1'b1;
    end else begin
      r_filt   <= {r_filt[FILTER_LEN-2:0], w_sync};
      r_rx_out <= w_maj;
    end
  end

  always_comb begin
    w_ones = 0;
    for (int i = 0; i < FILTER_LEN; i++) begin
      w_ones = w_ones + int'(r_filt[i]);
    end
  end

  assign w_maj = (w_ones > FILTER_LEN / 2);

  // Edges are seen on the clock where rx_out takes its new value
  assign w_rise = w_maj & ~r_rx_out;
  assign w_fall = ~w_maj & r_rx_out;
  assign w_edge = w_rise | w_fall;

  assign w_eff_rate_m1 = (bus.i_rate == '0) ? '0 : bus.i_rate - 16'd1;
  assign w_wrap        = (r_cnt >= w_eff_rate_m1);
  assign w_bits_nxt    = r_bits + 5'd1;
  assign w_bits_inc    = ~w_edge & w_wrap & (r_bits != 5'd31);
  assign w_hit_break   = w_bits_inc & (int'(w_bits_nxt) == BREAK_BITS);
  assign w_hit_idle    = w_bits_inc & (int'(w_bits_nxt) == IDLE_BITS);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_cnt  <= '0;
      r_bits <= '0;
    end else if (bus.i_clear || w_edge) begin
      r_cnt  <= '0;
      r_bits <= '0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      if (w_bits_inc) begin
        r_bits <= w_bits_nxt;
      end
    end else begin
      r_cnt  <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= ST_IDLE_HI;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_clear) begin
      w_state_nxt = ST_IDLE_HI;
    end else begin
      case (r_state)
        ST_IDLE_HI: if (w_fall)      w_state_nxt = ST_LOW;
        ST_LOW: begin
          if (w_rise)                w_state_nxt = ST_IDLE_HI;
          else if (w_hit_break)      w_state_nxt = ST_BREAK;
        end
        ST_BREAK:   if (w_rise)      w_state_nxt = ST_IDLE_HI;
        default:                     w_state_nxt = ST_IDLE_HI;
      endcase
    end
  end

  always_comb begin
    w_break_start_nxt = ~bus.i_clear & (r_state == ST_LOW) & w_hit_break;
    w_break_end_nxt   = ~bus.i_clear & (r_state == ST_BREAK) & w_rise;
    w_idle_nxt        = ~bus.i_clear & (r_state == ST_IDLE_HI) & w_hit_idle & r_idle_armed;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_idle_armed   <= 1'b0;
      r_break_start  <= 1'b0;
      r_break_active <= 1'b0;
      r_break_end    <= 1'b0;
      r_idle_pulse   <= 1'b0;
    end else begin
      if (bus.i_clear)     r_idle_armed <= 1'b0;
      else if (w_fall)     r_idle_armed <= 1'b1;
      else if (w_idle_nxt) r_idle_armed <= 1'b0;
      r_break_start  <= w_break_start_nxt;
      r_break_active <= (w_state_nxt == ST_BREAK);
      r_break_end    <= w_break_end_nxt;
      r_idle_pulse   <= w_idle_nxt;
    end
  end

  assign bus.o_rx_out       = r_rx_out;
  assign bus.o_break_start  = r_break_start;
  assign bus.o_break_active = r_break_active;
  assign bus.o_break_end    = r_break_end;
  assign bus.o_idle_pulse   = r_idle_pulse;

endmodule
`default_nettype wire

// File: doc/uart_rx_conditioner.md
UART_RX_CONDITIONER -- requirements
Module: uart_rx_conditioner

Interface
REQ-001 Parameters (name, default, meaning):
- SYNC_STAGES, 2: synchronizer depth, minimum 2.
- FILTER_LEN, 3: majority-filter window, odd, minimum 3.
- BREAK_BITS, 10: bit times of continuous low that declare a break.
- IDLE_BITS, 10: bit times of continuous high that declare idle.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- nReset, in, 1: reset, asynchronous, active-low.
- rx_pad, in, 1: raw asynchronous serial line.
- rate, in, 16: clocks per bit; 0 is treated as 1.
- clear, in, 1: synchronous soft clear.
- rx_out, out, 1: conditioned line, feeds the UART rx input.
- break_start, out, 1: one-cycle pulse when a break is declared.
- break_active, out, 1: level, high while in BREAK.
- break_end, out, 1: one-cycle pulse when a break ends.
- idle_pulse, out, 1: one-cycle pulse per idle period.

Function
REQ-003 Synchronizer: SYNC_STAGES flops clocked by clk; every stage reset to 1.
REQ-004 Filter shift register: FILTER_LEN bits, shifts in the synchronizer output every cycle; all bits reset to 1.
REQ-005 rx_out update: registered; each cycle it takes the majority value of the filter window.
REQ-006 Latency: a clean level change on rx_pad reaches rx_out after SYNC_STAGES + (FILTER_LEN+1)/2 + 1 clock edges (5 with defaults).
REQ-007 Glitch rejection: a synchronized pulse of ≤ (FILTER_LEN-1)/2 cycles does not change rx_out.
REQ-008 Bit timer: 16-bit cycle counter cnt plus 5-bit bit counter bits, both driven from rx_out.
- Each cycle cnt increments.
- When cnt ≥ eff_rate-1, cnt wraps to 0 and bits increments, where eff_rate = (rate==0 ? 1 : rate).
- bits saturates at 31.
REQ-009 Timer restart: any change of rx_out (compared with its previous-cycle value) zeroes cnt and bits in that cycle.
REQ-010 Rate change: a change of rate mid-count takes effect on the very next comparison; no other restart.
REQ-011 State machine: states IDLE_HI, LOW, BREAK, in the shared package; reset state IDLE_HI.
REQ-012 IDLE_HI transitions: on rx_out falling → LOW.
REQ-013 LOW transitions:
- rx_out rising → IDLE_HI.
- bits reaching BREAK_BITS while rx_out low → BREAK, with break_start high for exactly that cycle.
REQ-014 BREAK transitions: break_active=1; on rx_out rising → IDLE_HI, with break_end high for exactly that cycle.
REQ-015 Idle detection:
- An idle_armed flag is set by any falling edge of rx_out.
- In IDLE_HI, when bits reaches IDLE_BITS and idle_armed=1, idle_pulse is high one cycle and idle_armed clears.
- idle_armed reset value is 0, so there is no idle pulse after reset until the line has been low once.
REQ-016 Simultaneous events: a rx_out edge in the same cycle as a bit-counter threshold gives priority to the edge; no pulse is emitted.
REQ-017 clear=1 behaviour:
- State, cnt, bits and idle_armed return to their reset values next cycle.
- Synchronizer and filter are untouched, so rx_out keeps tracking the line.
- Pulses are suppressed during clear.
- If clear occurs while in BREAK, no break_end is produced.

Reset
REQ-018 Reset values while nReset=0:
- rx_out=1; break_start=0; break_active=0; break_end=0; idle_pulse=0.
- State IDLE_HI; cnt=0; bits=0; idle_armed=0; all synchronizer and filter bits =1.
REQ-019 Reset timing: reset asserts asynchronously, and its release is sampled on clk; reset during BREAK or LOW produces no pulses on any output.

Structure
REQ-020 Shared package uart_pkg holds:
- The state enum.
- The BREAK_BITS and IDLE_BITS defaults.
- The 16-bit rate type shared with the bus wrapper's rate register.
REQ-021 Sub-module: the synchronizer is a separate parameterised module, uart_sync; filter, timer and FSM stay in uart_rx_conditioner.
REQ-022 Output registering: all outputs are registered; there is no combinational path from rx_pad or rate to any output.

Verification
REQ-023 Step response: rx_pad 1→0 step with defaults → rx_out falls exactly 5 cycles after the sampling edge, then rises 5 cycles after the return step.
REQ-024 Glitch: rx_pad low for 1 cycle, then low for 2 cycles → rx_out stays 1 for the first pulse and falls for the second.
REQ-025 Break:
- Stimulus: rate=4, rx_pad held low 60 cycles, then high.
- break_start pulses 40 cycles after rx_out falls.
- break_active stays high until rx_out rises; break_end pulses in that cycle.
REQ-026 Idle: rate=4, one low bit, then the line stays high → one idle_pulse 40 cycles after rx_out rises, and no second pulse while the line stays high.
REQ-027 rate=0: low held 12 cycles → break_start 10 cycles after rx_out falls.
REQ-028 Interruptions:
- Assert nReset mid-BREAK → all outputs at reset values immediately, with no break_end.
- Repeat the same sequence with clear instead of nReset → state and outputs return to reset values next cycle, with no break_end.
